// File: rtl/ama_riscv_fe_ctrl_if.sv
// Frontend control bundle: decode/execute hints in, IMEM request and PC out.
// The master side is the frontend controller; the slave side is its environment.
interface ama_riscv_fe_ctrl_if;
    logic        dec_valid;
    logic [1:0]  dec_pc_sel;
    logic        dec_pc_we;
    logic        dec_branch;
    logic        dec_jalr;
    logic [31:0] jal_tgt;
    logic        exe_resolved;
    logic        exe_taken;
    logic [31:0] exe_tgt;
    logic        imem_ready;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] pc;
    logic        dec_bubble;
    logic        misaligned;
    logic [15:0] stall_cnt;

    modport master (
        input  dec_valid, dec_pc_sel, dec_pc_we, dec_branch, dec_jalr, jal_tgt,
        input  exe_resolved, exe_taken, exe_tgt, imem_ready,
        output imem_req, imem_addr, pc, dec_bubble, misaligned, stall_cnt
    );

    modport slave (
        output dec_valid, dec_pc_sel, dec_pc_we, dec_branch, dec_jalr, jal_tgt,
        output exe_resolved, exe_taken, exe_tgt, imem_ready,
        input  imem_req, imem_addr, pc, dec_bubble, misaligned, stall_cnt
    );
endinterface

// File: rtl/ama_riscv_fe_ctrl.sv
// RISC-V frontend PC controller: sequential fetch, JAL redirect in decode,
// and a hold-then-redirect sequence for branches/jalr resolved in EX.
module ama_riscv_fe_ctrl #(
    parameter logic [31:0] RESET_VEC = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 rst,
    ama_riscv_fe_ctrl_if.master  bus
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        WAIT_BR  = 2'd1,
        REDIRECT = 2'd2
    } state_t;

    localparam logic [1:0]  PC_SEL_JAL = 2'd1;
    localparam logic [31:0] ALIGN_MASK = ~32'd3;

    state_t      state_r, state_nxt_s;
    logic [31:0] pc_r, pc_nxt_s;
    logic [15:0] stall_r;
    logic        mis_r, mis_nxt_s;
    logic        jalr_pend_r, jalr_pend_nxt_s;
    logic        is_ctl_s, is_jal_s, stall_s;
    logic        imem_req_s, dec_bubble_s;
    logic        unused_s;

    assign unused_s = bus.dec_pc_we;
    assign is_ctl_s = bus.dec_valid & (bus.dec_branch | bus.dec_jalr);
    assign is_jal_s = bus.dec_valid & ~is_ctl_s & (bus.dec_pc_sel == PC_SEL_JAL);

    // State, PC, pending kind and misalignment flag registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= RUN;
            pc_r        <= RESET_VEC;
            mis_r       <= 1'b0;
            jalr_pend_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            pc_r        <= pc_nxt_s;
            mis_r       <= mis_nxt_s;
            jalr_pend_r <= jalr_pend_nxt_s;
        end
    end

    // Next-state and next-PC selection
    always_comb begin
        state_nxt_s     = state_r;
        pc_nxt_s        = pc_r;
        mis_nxt_s       = 1'b0;
        jalr_pend_nxt_s = jalr_pend_r;
        case (state_r)
            RUN: begin
                if (is_ctl_s) begin
                    state_nxt_s     = WAIT_BR;
                    jalr_pend_nxt_s = bus.dec_jalr;
                end else if (is_jal_s) begin
                    pc_nxt_s  = bus.jal_tgt & ALIGN_MASK;
                    mis_nxt_s = |bus.jal_tgt[1:0];
                end else if (bus.imem_ready) begin
                    pc_nxt_s = pc_r + 32'd4;
                end else begin
                    pc_nxt_s = pc_r;
                end
            end
            WAIT_BR: begin
                // jalr is unconditionally taken; exe_taken only qualifies branches
                if (bus.exe_resolved && (bus.exe_taken || jalr_pend_r)) begin
                    pc_nxt_s    = bus.exe_tgt & ALIGN_MASK;
                    mis_nxt_s   = |bus.exe_tgt[1:0];
                    state_nxt_s = REDIRECT;
                end else if (bus.exe_resolved) begin
                    state_nxt_s = RUN;
                end else begin
                    state_nxt_s = WAIT_BR;
                end
            end
            REDIRECT: begin
                if (bus.imem_ready) begin
                    pc_nxt_s    = pc_r + 32'd4;
                    state_nxt_s = RUN;
                end else begin
                    state_nxt_s = REDIRECT;
                end
            end
            default: begin
                state_nxt_s = RUN;
            end
        endcase
    end

    // Output decode of state plus the same-cycle JAL kill
    always_comb begin
        imem_req_s   = 1'b1;
        dec_bubble_s = 1'b0;
        case (state_r)
            RUN: begin
                imem_req_s   = 1'b1;
                dec_bubble_s = is_jal_s;
            end
            WAIT_BR: begin
                imem_req_s   = 1'b0;
                dec_bubble_s = 1'b1;
            end
            REDIRECT: begin
                imem_req_s   = 1'b1;
                dec_bubble_s = 1'b1;
            end
            default: begin
                imem_req_s   = 1'b1;
                dec_bubble_s = 1'b0;
            end
        endcase
    end

    assign stall_s = (state_r == WAIT_BR) | (imem_req_s & ~bus.imem_ready);

    // Saturating frontend stall counter
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_r <= 16'd0;
        end else if (stall_s && (stall_r != 16'hFFFF)) begin
            stall_r <= stall_r + 16'd1;
        end else begin
            stall_r <= stall_r;
        end
    end

    assign bus.imem_req   = imem_req_s;
    assign bus.imem_addr  = pc_r;
    assign bus.pc         = pc_r;
    assign bus.dec_bubble = dec_bubble_s;
    assign bus.misaligned = mis_r;
    assign bus.stall_cnt  = stall_r;

endmodule

// File: tb/tb_ama_riscv_fe_ctrl.sv
// Self-checking bench for ama_riscv_fe_ctrl: directed scenarios plus random
// stimulus, all compared against a cycle-level reference model of the frontend.
module tb_ama_riscv_fe_ctrl;

    localparam logic [31:0] RV = 32'h0000_0000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ama_riscv_fe_ctrl_if bus ();

    ama_riscv_fe_ctrl #(.RESET_VEC(RV)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: mode 0 = fetching, 1 = waiting on EX, 2 = refetching target
    int          m_mode;
    logic [31:0] m_pc;
    int          m_stall;
    bit          m_mis;
    bit          m_jalr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        bus.dec_valid    = 1'b0;
        bus.dec_pc_sel   = 2'd0;
        bus.dec_pc_we    = 1'b0;
        bus.dec_branch   = 1'b0;
        bus.dec_jalr     = 1'b0;
        bus.jal_tgt      = 32'd0;
        bus.exe_resolved = 1'b0;
        bus.exe_taken    = 1'b0;
        bus.exe_tgt      = 32'd0;
        bus.imem_ready   = 1'b1;
    endtask

    function automatic logic [31:0] aligned(input logic [31:0] a);
        return a - (a % 32'd4);
    endfunction

    function automatic void model_next();
        bit ctl;
        bit jal;
        if (rst) begin
            m_mode  = 0;
            m_pc    = RV;
            m_stall = 0;
            m_mis   = 1'b0;
            m_jalr  = 1'b0;
            return;
        end
        // a fetch cycle stalls when IMEM refuses; waiting on EX is always a stall
        if ((m_mode == 1) || !bus.imem_ready)
            m_stall = (m_stall >= 65535) ? 65535 : m_stall + 1;
        m_mis = 1'b0;
        ctl = bus.dec_valid && (bus.dec_branch || bus.dec_jalr);
        jal = bus.dec_valid && !ctl && (bus.dec_pc_sel == 2'd1);
        if (m_mode == 0) begin
            if (ctl) begin
                m_jalr = bus.dec_jalr;
                m_mode = 1;
            end else if (jal) begin
                m_pc  = aligned(bus.jal_tgt);
                m_mis = (bus.jal_tgt % 32'd4) != 32'd0;
            end else if (bus.imem_ready) begin
                m_pc = m_pc + 32'd4;
            end
        end else if (m_mode == 1) begin
            if (bus.exe_resolved) begin
                if (bus.exe_taken || m_jalr) begin
                    m_pc   = aligned(bus.exe_tgt);
                    m_mis  = (bus.exe_tgt % 32'd4) != 32'd0;
                    m_mode = 2;
                end else begin
                    m_mode = 0;
                end
            end
        end else begin
            if (bus.imem_ready) begin
                m_pc   = m_pc + 32'd4;
                m_mode = 0;
            end
        end
    endfunction

    // One clock: compare outputs at the falling edge, advance the model, cross the rising edge
    task automatic step(input bit do_chk);
        bit exp_bubble;
        @(negedge clk);
        if (do_chk) begin
            exp_bubble = (m_mode != 0) ||
                         (bus.dec_valid && !(bus.dec_branch || bus.dec_jalr) && bus.dec_pc_sel == 2'd1);
            chk("imem_req",   32'(bus.imem_req),   32'(m_mode != 1));
            chk("imem_addr",  bus.imem_addr,       m_pc);
            chk("pc",         bus.pc,              m_pc);
            chk("dec_bubble", 32'(bus.dec_bubble), 32'(exp_bubble));
            chk("misaligned", 32'(bus.misaligned), 32'(m_mis));
            chk("stall_cnt",  32'(bus.stall_cnt),  32'(m_stall));
        end
        model_next();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int st0;
        idle_inputs();
        rst = 1'b1;
        m_mode = 0; m_pc = RV; m_stall = 0; m_mis = 1'b0; m_jalr = 1'b0;
        #1;
        step(1'b0);
        step(1'b1);
        chk("rst_pc",       bus.pc,              RV);
        chk("rst_imem_req", 32'(bus.imem_req),   32'd1);
        chk("rst_bubble",   32'(bus.dec_bubble), 32'd0);

        // sequential fetch
        rst = 1'b0;
        for (int i = 0; i < 4; i++) step(1'b1);
        chk("seq_pc",    bus.pc,             32'h10);
        chk("seq_stall", 32'(bus.stall_cnt), 32'd0);
        for (int i = 0; i < 4; i++) step(1'b1);
        chk("seq_pc20", bus.pc, 32'h20);

        // taken branch at 0x20, resolved in the third waiting cycle
        bus.dec_valid = 1'b1; bus.dec_branch = 1'b1;
        step(1'b1);
        idle_inputs();
        step(1'b1);
        step(1'b1);
        bus.exe_resolved = 1'b1; bus.exe_taken = 1'b1; bus.exe_tgt = 32'h100;
        step(1'b1);
        idle_inputs();
        chk("br_pc", bus.pc, 32'h100);
        chk("br_bubble", 32'(bus.dec_bubble), 32'd1);
        step(1'b1);
        chk("br_stall", 32'(bus.stall_cnt), 32'd3);
        chk("br_pc_next", bus.pc, 32'h104);

        // JAL to 0x40, then a branch resolved not-taken after one cycle
        bus.dec_valid = 1'b1; bus.dec_pc_sel = 2'd1; bus.jal_tgt = 32'h40;
        step(1'b1);
        idle_inputs();
        bus.dec_valid = 1'b1; bus.dec_branch = 1'b1;
        step(1'b1);
        idle_inputs();
        bus.exe_resolved = 1'b1; bus.exe_taken = 1'b0;
        step(1'b1);
        idle_inputs();
        chk("nt_pc", bus.pc, 32'h40);
        chk("nt_req", 32'(bus.imem_req), 32'd1);

        // jalr to a misaligned target ignores exe_taken
        bus.dec_valid = 1'b1; bus.dec_jalr = 1'b1;
        step(1'b1);
        idle_inputs();
        bus.exe_resolved = 1'b1; bus.exe_taken = 1'b0; bus.exe_tgt = 32'h203;
        step(1'b1);
        idle_inputs();
        chk("jalr_pc",  bus.pc,              32'h200);
        chk("jalr_mis", 32'(bus.misaligned), 32'd1);
        bus.imem_ready = 1'b0;
        step(1'b1);
        chk("jalr_mis_clr", 32'(bus.misaligned), 32'd0);
        bus.imem_ready = 1'b1;
        step(1'b1);

        // JAL while IMEM stalls
        st0 = int'(bus.stall_cnt);
        bus.imem_ready = 1'b0; bus.dec_valid = 1'b1; bus.dec_pc_sel = 2'd1; bus.jal_tgt = 32'h80;
        step(1'b1);
        idle_inputs();
        chk("jal_pc",    bus.pc,             32'h80);
        chk("jal_stall", 32'(bus.stall_cnt), 32'(st0 + 1));
        step(1'b1);

        // reset while waiting with a resolve in the same cycle
        bus.dec_valid = 1'b1; bus.dec_branch = 1'b1;
        step(1'b1);
        idle_inputs();
        rst = 1'b1; bus.exe_resolved = 1'b1; bus.exe_taken = 1'b1; bus.exe_tgt = 32'h300;
        step(1'b1);
        rst = 1'b0;
        idle_inputs();
        chk("rstw_pc",    bus.pc,              RV);
        chk("rstw_req",   32'(bus.imem_req),   32'd1);
        chk("rstw_bub",   32'(bus.dec_bubble), 32'd0);
        chk("rstw_stall", 32'(bus.stall_cnt),  32'd0);
        step(1'b1);

        // PC wrap at the top of the address space
        bus.dec_valid = 1'b1; bus.dec_pc_sel = 2'd1; bus.jal_tgt = 32'hFFFF_FFFC;
        step(1'b1);
        idle_inputs();
        chk("wrap_top", bus.pc, 32'hFFFF_FFFC);
        step(1'b1);
        chk("wrap_pc", bus.pc, 32'h0);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            rst              = ($urandom % 100) == 0;
            bus.dec_valid    = $urandom_range(0, 1);
            bus.dec_pc_sel   = 2'($urandom % 4);
            bus.dec_pc_we    = $urandom_range(0, 1);
            bus.dec_branch   = ($urandom % 4) == 0;
            bus.dec_jalr     = ($urandom % 6) == 0;
            bus.jal_tgt      = $urandom;
            bus.exe_resolved = ($urandom % 3) == 0;
            bus.exe_taken    = $urandom_range(0, 1);
            bus.exe_tgt      = $urandom;
            bus.imem_ready   = ($urandom % 4) != 0;
            step(1'b1);
        end

        // stall counter saturation
        rst = 1'b1;
        idle_inputs();
        step(1'b1);
        rst = 1'b0;
        bus.imem_ready = 1'b0;
        for (int i = 0; i < 70000; i++) step(1'b0);
        chk("sat_cnt", 32'(bus.stall_cnt), 32'h0000_FFFF);
        step(1'b1);
        step(1'b1);
        chk("sat_hold", 32'(bus.stall_cnt), 32'h0000_FFFF);
        chk("sat_pc",   bus.pc,             RV);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule

// File: doc/ama_riscv_fe_ctrl.md
AMA_RISCV_FE_CTRL -- requirements
Module: ama_riscv_fe_ctrl

Interface
REQ-001 The block SHALL have one parameter: RESET_VEC, default 32'h0000_0000, the PC value loaded on reset.
REQ-002 The block SHALL use one clock; reset is synchronous and active-high.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 dec_valid  in  1  decode stage holds a valid instruction.
REQ-006 dec_pc_sel  in  2  decoder pc_sel: 0=INC4, 1=JAL; other values are treated as INC4.
REQ-007 dec_pc_we  in  1  decoder pc_we; 0 with dec_branch|dec_jalr means "resolved later".
REQ-008 dec_branch, dec_jalr  in  1 each  decoder itype.branch / itype.jalr.
REQ-009 jal_tgt  in  32  JAL target computed in decode.
REQ-010 exe_resolved  in  1  EX resolves the pending branch/jalr this cycle.
REQ-011 exe_taken  in  1  branch outcome; ignored for jalr (always taken).
REQ-012 exe_tgt  in  32  redirect target from EX.
REQ-013 imem_ready  in  1  IMEM accepts the request this cycle.
REQ-014 imem_req  out  1  fetch request valid.
REQ-015 imem_addr  out  32  fetch address, equal to pc.
REQ-016 pc  out  32  current fetch PC register.
REQ-017 dec_bubble  out  1  kill the instruction entering decode (insert NOP).
REQ-018 misaligned  out  1  single-cycle pulse: redirect target had bits[1:0] != 0.
REQ-019 stall_cnt  out  16  saturating count of frontend stall cycles.

Function
REQ-020 The block SHALL implement the FSM states RUN, WAIT_BR and REDIRECT.
REQ-021 RUN: imem_req=1, dec_bubble=0.
- dec_valid & (dec_branch|dec_jalr): pc holds, go WAIT_BR.
- else dec_valid & dec_pc_sel==JAL: pc<=jal_tgt & ~3, dec_bubble=1 this cycle, stay RUN.
- else imem_ready: pc<=pc+4 (mod 2^32, wrap at 32'hFFFF_FFFC -> 0).
- else pc holds.
REQ-022 Branch/jalr detection SHALL take priority over JAL and over imem_ready in the same cycle.
REQ-023 WAIT_BR: imem_req=0, dec_bubble=1.
- exe_resolved=0: stay WAIT_BR.
- exe_resolved=1 with taken (exe_taken=1 or pending jalr): pc<=exe_tgt & ~3, go REDIRECT.
- exe_resolved=1, branch not taken: pc holds, go RUN.
REQ-024 The block SHALL latch which kind (branch or jalr) is pending on entry to WAIT_BR, in a 1-bit register.
REQ-025 misaligned SHALL pulse in the cycle after a taken redirect or JAL whose target bits[1:0] != 0; the PC still loads the target with bits[1:0] cleared.
REQ-026 REDIRECT: imem_req=1, dec_bubble=1, and dec_* inputs are ignored.
- imem_ready: pc<=pc+4, go RUN.
- otherwise: stay.
REQ-027 exe_resolved SHALL be ignored in RUN and REDIRECT.
REQ-028 stall_cnt SHALL increment by 1 in each cycle where state==WAIT_BR, or imem_req=1 with imem_ready=0, and SHALL saturate at 16'hFFFF.
REQ-029 All outputs SHALL be registered or pure decode of state/pc; imem_addr SHALL equal pc combinationally.

Reset
REQ-030 With rst=1 at a clock edge, the block SHALL take these values regardless of other inputs, including mid-WAIT_BR:
- state=RUN
- pc=RESET_VEC
- stall_cnt=0
- misaligned=0
- pending kind cleared
REQ-031 During and after reset, outputs SHALL be imem_req=1, dec_bubble=0, imem_addr=RESET_VEC.

Verification
REQ-032 Sequential fetch: reset, imem_ready=1 for 4 cycles -> pc 0,4,8,C,10; dec_bubble=0; stall_cnt=0.
REQ-033 Taken branch: dec_valid=1, dec_branch=1 at pc=0x20.
- 3 WAIT_BR cycles, then exe_resolved=1, exe_taken=1, exe_tgt=0x100 -> REDIRECT with pc=0x100.
- dec_bubble=1 for 4 cycles; stall_cnt=3 (or more if imem_ready=0 in REDIRECT).
REQ-034 Not-taken branch and jalr:
- Branch at pc=0x40 resolved not-taken after 1 cycle -> RUN, pc=0x40.
- jalr with exe_taken=0, exe_tgt=0x203 -> pc=0x200; misaligned pulses once.
REQ-035 JAL with IMEM stall: dec_pc_sel=JAL, jal_tgt=0x80 with imem_ready=0 -> pc=0x80, dec_bubble one cycle, stall_cnt increments.
REQ-036 Reset mid-WAIT_BR with exe_resolved=1 in the same cycle -> pc=RESET_VEC, state RUN, no redirect.
REQ-037 Saturation and wrap:
- imem_ready=0 for 70000 cycles -> stall_cnt=16'hFFFF, holds.
- pc=32'hFFFF_FFFC with imem_ready=1 -> pc=0.
